subcarrier_mapper: RTL and testbench

SUBCARRIER_MAPPER -- requirements
Module: subcarrier_mapper

---
 rtl/subcarrier_mapper_pkg.sv | 53 +++++
 rtl/subcarrier_mapper_gray_level_map.sv | 40 ++++
 rtl/subcarrier_mapper.sv | 152 +++++++++++++++
 tb/tb_subcarrier_mapper.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/subcarrier_mapper_pkg.sv
// Shared transmitter definitions: 802.11a RATE codes, modulation decode and
// the per-symbol data-subcarrier count used by the subcarrier mapper.
package subcarrier_mapper_pkg;

  localparam int unsigned NUM_DATA_SC = 48;
  localparam logic [5:0]  SC_LAST     = 6'(NUM_DATA_SC - 1);
  localparam int unsigned BUF_BITS    = 8;

  localparam logic [3:0] RATE_6M  = 4'b1101;
  localparam logic [3:0] RATE_9M  = 4'b1111;
  localparam logic [3:0] RATE_12M = 4'b0101;
  localparam logic [3:0] RATE_18M = 4'b0111;
  localparam logic [3:0] RATE_24M = 4'b1001;
  localparam logic [3:0] RATE_36M = 4'b1011;
  localparam logic [3:0] RATE_48M = 4'b0001;
  localparam logic [3:0] RATE_54M = 4'b0011;
  localparam logic [3:0] RATE_RESET = RATE_6M;

  typedef enum logic [1:0] {
    MOD_BPSK  = 2'd0,
    MOD_QPSK  = 2'd1,
    MOD_QAM16 = 2'd2,
    MOD_QAM64 = 2'd3
  } mod_e;

  // Number of Gray-coded levels on one axis (zero = axis unused).
  typedef enum logic [1:0] {
    LVL_ZERO = 2'd0,
    LVL_2    = 2'd1,
    LVL_4    = 2'd2,
    LVL_8    = 2'd3
  } lvl_mode_e;

  function automatic mod_e rate_to_mod(input logic [3:0] r);
    case (r)
      RATE_6M,  RATE_9M:  return MOD_BPSK;
      RATE_12M, RATE_18M: return MOD_QPSK;
      RATE_24M, RATE_36M: return MOD_QAM16;
      RATE_48M, RATE_54M: return MOD_QAM64;
      default:            return MOD_BPSK;
    endcase
  endfunction

  function automatic logic [3:0] n_bpsc(input mod_e m);
    case (m)
      MOD_QPSK:  return 4'd2;
      MOD_QAM16: return 4'd4;
      MOD_QAM64: return 4'd6;
      default:   return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/subcarrier_mapper_gray_level_map.sv
// Gray-coded bits to signed amplitude for one constellation axis.
// Bits are MSB-aligned: bits[2] is the oldest bit of the axis group.
module gray_level_map
  import subcarrier_mapper_pkg::*;
(
  input  lvl_mode_e          mode,
  input  logic [2:0]         bits,
  output logic signed [3:0]  level
);

  always_comb begin
    level = 4'sd0;
    case (mode)
      LVL_ZERO: level = 4'sd0;
      LVL_2:    level = bits[2] ? 4'sd1 : -4'sd1;
      LVL_4: begin
        case (bits[2:1])
          2'b00:   level = -4'sd3;
          2'b01:   level = -4'sd1;
          2'b11:   level = 4'sd1;
          default: level = 4'sd3;
        endcase
      end
      LVL_8: begin
        case (bits)
          3'b000:  level = -4'sd7;
          3'b001:  level = -4'sd5;
          3'b011:  level = -4'sd3;
          3'b010:  level = -4'sd1;
          3'b110:  level = 4'sd1;
          3'b111:  level = 4'sd3;
          3'b101:  level = 4'sd5;
          default: level = 4'sd7;
        endcase
      end
      default: level = 4'sd0;
    endcase
  end

endmodule

// File: rtl/subcarrier_mapper.sv
// 802.11a data-subcarrier mapper: buffers interleaved bit pairs and emits one
// BPSK/QPSK/16QAM/64QAM I/Q point per data subcarrier with valid/ready output.
module subcarrier_mapper
  import subcarrier_mapper_pkg::*;
(
  input  logic               Clk,
  input  logic               reset,
  input  logic [3:0]         rate,
  input  logic               A_in,
  input  logic               B_in,
  input  logic               AB_in_valid,
  output logic               AB_in_ready,
  output logic signed [3:0]  I_out,
  output logic signed [3:0]  Q_out,
  output logic               IQ_valid,
  input  logic               IQ_ready,
  output logic [5:0]         sc_index,
  output logic               sym_last
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // AB_in_ready depends only on the buffer fill; IQ_valid never waits on
  // IQ_ready, and the output point is held while IQ_valid && !IQ_ready.

  logic [BUF_BITS-1:0] buf_q, buf_d;
  logic [3:0]          count_q, count_d;
  logic [3:0]          rate_q, rate_d;
  logic [5:0]          sc_next_q, sc_next_d;
  logic [5:0]          sc_index_q, sc_index_d;
  logic                iq_valid_q, iq_valid_d;
  logic signed [3:0]   i_q, i_d;
  logic signed [3:0]   q_q, q_d;

  mod_e                mod;
  logic [3:0]          n_bits;
  logic                accept;
  logic                out_free;
  logic                pop;
  logic [2:0]          base;
  logic [2:0]          i_bits, q_bits;
  lvl_mode_e           i_mode, q_mode;
  logic signed [3:0]   i_level, q_level;

  assign mod         = rate_to_mod(rate_q);
  assign n_bits      = n_bpsc(mod);
  assign AB_in_ready = (count_q <= 4'd6);
  assign accept      = AB_in_valid && AB_in_ready;
  assign out_free    = !iq_valid_q || IQ_ready;
  assign pop         = (count_q >= n_bits) && out_free;

  // buf_q[0] is the oldest bit; each axis takes its bits oldest-first as MSB.
  always_comb begin
    i_bits = {buf_q[0], 2'b00};
    q_bits = 3'b000;
    i_mode = LVL_2;
    q_mode = LVL_ZERO;
    case (mod)
      MOD_QPSK: begin
        q_bits = {buf_q[1], 2'b00};
        q_mode = LVL_2;
      end
      MOD_QAM16: begin
        i_bits = {buf_q[0], buf_q[1], 1'b0};
        q_bits = {buf_q[2], buf_q[3], 1'b0};
        i_mode = LVL_4;
        q_mode = LVL_4;
      end
      MOD_QAM64: begin
        i_bits = {buf_q[0], buf_q[1], buf_q[2]};
        q_bits = {buf_q[3], buf_q[4], buf_q[5]};
        i_mode = LVL_8;
        q_mode = LVL_8;
      end
      default: ;
    endcase
  end

  gray_level_map u_map_i (
    .mode  (i_mode),
    .bits  (i_bits),
    .level (i_level)
  );

  gray_level_map u_map_q (
    .mode  (q_mode),
    .bits  (q_bits),
    .level (q_level)
  );

  // New pair lands just above whatever survives this edge's pop.
  always_comb begin
    base    = count_q[2:0] - (pop ? n_bits[2:0] : 3'd0);
    buf_d   = pop ? (buf_q >> n_bits) : buf_q;
    if (accept) begin
      buf_d[base]        = A_in;
      buf_d[base + 3'd1] = B_in;
    end
    count_d = count_q + (accept ? 4'd2 : 4'd0) - (pop ? n_bits : 4'd0);
  end

  // Rate only changes between symbols, with nothing buffered or pending.
  always_comb begin
    rate_d = rate_q;
    if ((count_q == 4'd0) && out_free && (sc_next_q == 6'd0)) begin
      rate_d = rate;
    end
  end

  always_comb begin
    iq_valid_d = iq_valid_q && !IQ_ready;
    i_d        = i_q;
    q_d        = q_q;
    sc_index_d = sc_index_q;
    sc_next_d  = sc_next_q;
    if (pop) begin
      iq_valid_d = 1'b1;
      i_d        = i_level;
      q_d        = q_level;
      sc_index_d = sc_next_q;
      sc_next_d  = (sc_next_q == SC_LAST) ? 6'd0 : sc_next_q + 6'd1;
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      buf_q      <= '0;
      count_q    <= '0;
      rate_q     <= RATE_RESET;
      sc_next_q  <= '0;
      sc_index_q <= '0;
      iq_valid_q <= 1'b0;
      i_q        <= '0;
      q_q        <= '0;
    end else begin
      buf_q      <= buf_d;
      count_q    <= count_d;
      rate_q     <= rate_d;
      sc_next_q  <= sc_next_d;
      sc_index_q <= sc_index_d;
      iq_valid_q <= iq_valid_d;
      i_q        <= i_d;
      q_q        <= q_d;
    end
  end

  assign I_out    = i_q;
  assign Q_out    = q_q;
  assign IQ_valid = iq_valid_q;
  assign sc_index = sc_index_q;
  assign sym_last = (sc_index_q == SC_LAST);

endmodule

// File: tb/tb_subcarrier_mapper.sv
// Directed bench for subcarrier_mapper: hand-computed I/Q points go into an
// expected queue that a negedge monitor checks on every accepted subcarrier.
module tb_subcarrier_mapper;

  logic       Clk;
  logic       reset;
  logic [3:0] rate;
  logic       A_in;
  logic       B_in;
  logic       AB_in_valid;
  logic       AB_in_ready;
  logic [3:0] I_out;
  logic [3:0] Q_out;
  logic       IQ_valid;
  logic       IQ_ready;
  logic [5:0] sc_index;
  logic       sym_last;

  int checks   = 0;
  int failures = 0;

  // Expected word: {sc_index, sym_last, I, Q}
  logic [14:0] exp_q[$];
  logic [5:0]  exp_sc;

  subcarrier_mapper dut (
    .Clk         (Clk),
    .reset       (reset),
    .rate        (rate),
    .A_in        (A_in),
    .B_in        (B_in),
    .AB_in_valid (AB_in_valid),
    .AB_in_ready (AB_in_ready),
    .I_out       (I_out),
    .Q_out       (Q_out),
    .IQ_valid    (IQ_valid),
    .IQ_ready    (IQ_ready),
    .sc_index    (sc_index),
    .sym_last    (sym_last)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset(input logic [3:0] r);
    AB_in_valid = 1'b0;
    IQ_ready    = 1'b1;
    rate        = r;
    reset       = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    exp_sc = 6'd0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic [3:0] i, input logic [3:0] q);
    exp_q.push_back({exp_sc, (exp_sc == 6'd47), i, q});
    exp_sc = (exp_sc == 6'd47) ? 6'd0 : exp_sc + 6'd1;
  endtask

  function automatic logic [3:0] pm1(input logic b);
    return b ? 4'h1 : 4'hf;
  endfunction

  task automatic send_pair(input logic a, input logic b);
    int n = 0;
    A_in = a;
    B_in = b;
    AB_in_valid = 1'b1;
    while (!AB_in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("send_ready_timeout", AB_in_ready, 1'b1);
    step();
    AB_in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      step();
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge Clk) begin
    logic [14:0] e;
    if (!reset && IQ_valid && IQ_ready) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 15'h7fff;
      check("sc_out", {sc_index, sym_last, I_out, Q_out}, e);
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int win;
    int npairs;
    int nvalid;
    int k;
    int n;

    reset = 1'b0; rate = 4'b0011; A_in = 1'b0; B_in = 1'b0;
    AB_in_valid = 1'b0; IQ_ready = 1'b1; exp_sc = 6'd0;

    // Reset state, checked before any clock edge and again after edges.
    #1 reset = 1'b1;
    #2;
    check("rst_valid", IQ_valid, 1'b0);
    check("rst_i", I_out, 4'h0);
    check("rst_q", Q_out, 4'h0);
    check("rst_sc", sc_index, 6'd0);
    check("rst_last", sym_last, 1'b0);
    check("rst_count", dut.count_q, 4'd0);
    check("rst_rate", dut.rate_q, 4'b1101);
    check("rst_ready", AB_in_ready, 1'b1);
    repeat (3) @(posedge Clk);
    #1;
    check("rst_rate_clk", dut.rate_q, 4'b1101);
    check("rst_valid_clk", IQ_valid, 1'b0);

    // BPSK: (1,0) continuously -> +1,-1 alternating, one pair per 2 cycles.
    apply_reset(4'b1101);
    AB_in_valid = 1'b1; A_in = 1'b1; B_in = 1'b0;
    win = 0;
    for (int c = 0; c < 40; c++) begin
      if (AB_in_ready) begin
        push_exp(4'h1, 4'h0);
        push_exp(4'hf, 4'h0);
        if (c >= 20) win++;
      end
      step();
    end
    AB_in_valid = 1'b0;
    check("bpsk_pairs_in_20cyc", win, 10);
    wait_drain("bpsk_drain");

    // 16QAM: (1,0),(1,1) -> bits 1011 -> I=10:+3, Q=11:+1; one edge latency.
    apply_reset(4'b1001);
    push_exp(4'h3, 4'h1);
    send_pair(1'b1, 1'b0);
    send_pair(1'b1, 1'b1);
    check("qam16_lat_before", IQ_valid, 1'b0);
    step();
    check("qam16_lat_after", IQ_valid, 1'b1);
    wait_drain("qam16_drain");
    check("qam16_count", dut.count_q, 4'd0);

    // 64QAM: bits 100 011 -> +7,-3 ; bits 100 111 -> +7,+3.
    apply_reset(4'b0001);
    push_exp(4'h7, 4'hd);
    push_exp(4'h7, 4'h3);
    send_pair(1'b1, 1'b0);
    send_pair(1'b0, 1'b0);
    send_pair(1'b1, 1'b1);
    send_pair(1'b1, 1'b0);
    send_pair(1'b0, 1'b1);
    send_pair(1'b1, 1'b1);
    // Steady state with all-ones bits: +3,+3 once every 3 cycles.
    AB_in_valid = 1'b1; A_in = 1'b1; B_in = 1'b1;
    npairs = 0; nvalid = 0;
    for (int c = 0; c < 45; c++) begin
      if (c >= 12 && c < 42 && IQ_valid) nvalid++;
      if (AB_in_ready) begin
        npairs++;
        if (npairs % 3 == 0) push_exp(4'h3, 4'h3);
      end
      step();
    end
    AB_in_valid = 1'b0;
    check("qam64_sc_in_30cyc", nvalid, 10);
    wait_drain("qam64_drain");
    // Partial group stays buffered.
    check("qam64_leftover", dut.count_q, 2 * (npairs % 3));

    // QPSK backpressure: IQ_ready low for 10 cycles.
    apply_reset(4'b0101);
    IQ_ready = 1'b0;
    AB_in_valid = 1'b1;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      A_in = ~k[0];
      B_in = k[1];
      if (AB_in_ready) begin
        push_exp(pm1(A_in), pm1(B_in));
        k++;
      end
      step();
    end
    AB_in_valid = 1'b0;
    check("bp_count", dut.count_q, 4'd8);
    check("bp_ready", AB_in_ready, 1'b0);
    check("bp_valid", IQ_valid, 1'b1);
    check("bp_i_held", I_out, 4'h1);
    check("bp_q_held", Q_out, 4'hf);
    check("bp_sc_held", sc_index, 6'd0);
    check("bp_pairs", k, 5);
    IQ_ready = 1'b1;
    for (int j = 5; j < 15; j++) begin
      push_exp(pm1(~j[0]), pm1(j[1]));
      send_pair(~j[0], j[1]);
    end
    wait_drain("bp_drain");

    // Symbol wrap under QPSK; rate change mid-symbol waits for the boundary.
    apply_reset(4'b0101);
    for (int j = 0; j < 48; j++) begin
      if (j == 20) rate = 4'b1001;
      push_exp(pm1(j[0]), pm1(j[2]));
      send_pair(j[0], j[2]);
    end
    repeat (3) step();
    // 16QAM: bits 0001 -> -3,-1 ; bits 1110 -> +1,+3, starting at sc 0.
    push_exp(4'hd, 4'hf);
    push_exp(4'h1, 4'h3);
    send_pair(1'b0, 1'b0);
    send_pair(1'b0, 1'b1);
    send_pair(1'b1, 1'b1);
    send_pair(1'b1, 1'b0);
    wait_drain("wrap_drain");
    check("wrap_rate", dut.rate_q, 4'b1001);

    // Reset mid-symbol at sc_index 20 with 3 bits buffered (BPSK).
    apply_reset(4'b1101);
    for (int j = 0; j < 10; j++) begin
      push_exp(4'h1, 4'h0);
      push_exp(4'hf, 4'h0);
      send_pair(1'b1, 1'b0);
    end
    wait_drain("pre_rst_drain");
    IQ_ready = 1'b0;
    send_pair(1'b1, 1'b0);
    send_pair(1'b0, 1'b1);
    check("pre_rst_sc", sc_index, 6'd20);
    check("pre_rst_count", dut.count_q, 4'd3);
    check("pre_rst_valid", IQ_valid, 1'b1);
    reset = 1'b1;
    #2;
    check("mid_rst_valid", IQ_valid, 1'b0);
    check("mid_rst_i", I_out, 4'h0);
    check("mid_rst_q", Q_out, 4'h0);
    check("mid_rst_sc", sc_index, 6'd0);
    check("mid_rst_last", sym_last, 1'b0);
    check("mid_rst_count", dut.count_q, 4'd0);
    apply_reset(4'b1101);
    push_exp(4'h1, 4'h0);
    push_exp(4'h1, 4'h0);
    send_pair(1'b1, 1'b1);
    n = 0;
    while (!IQ_valid && n < 20) begin
      step();
      n++;
    end
    check("post_rst_valid", IQ_valid, 1'b1);
    check("post_rst_sc", sc_index, 6'd0);
    wait_drain("post_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
